sici_pcs_mf_ctrl: RTL
=====================

Name: sici_pcs_mf_ctrl

Overview:
Multiframe sequencer for the SICI PCS overhead inserter. Generates the 8-bit multiframe index PCS_MFI (0..255) and the reserved-SH bit stream PCS_SH_Res. Accepts reserved-channel words through a valid/ready handshake. Schedules test error injection (Err_SH/Err_MF/Err_CRC) aligned to whole multiframes. Sits between the management/config logic and the overhead inserter, sharing its Ck/CE domain.

Parameters:
RW, 16, reserved-channel word width in bits; legal range 1..213.
RES_START, 27, first MFI index carrying a reserved bit; RES_START+RW-1 must be <= 239.

Ports:
Ck  input  1  clock
Rs_n  input  1  asynchronous reset, active low
CE  input  1  clock enable, active high; all state holds when 0
En  input  1  run request level
Run  output  1  1 while in RUN or STOP state
PCS_MFI  output  8  multiframe index to inserter
PCS_SH_Res  output  1  reserved SH bit, valid together with PCS_MFI
MF_Start  output  1  one-CE-cycle pulse while PCS_MFI==0 in RUN
Res_Word  input  RW  reserved-channel word, MSB sent first
Res_Vld  input  1  word valid
Res_Rdy  output  1  holding register empty
Res_Und  output  1  one-cycle pulse: no word available at load point
Inj_Req  input  1  error-injection request level
Inj_Sel  input  3  bit0 SH, bit1 MF, bit2 CRC
Inj_Num  input  8  multiframes to corrupt; 0 is treated as 1
Inj_Ack  output  1  one-cycle pulse, request accepted
Inj_Busy  output  1  injection armed or active
Inj_Done  output  1  one-cycle pulse, injection finished or aborted
Err_SH, Err_MF, Err_CRC  output  1 each  error controls to inserter

Behaviour:
- Clock and reset are fixed: one clock Ck; Rs_n is asynchronous, active low. All registers advance only when CE=1.
- All outputs are registered. Reset values: every output 0; state IDLE; holding register and shift register empty/zero.
- FSM IDLE: PCS_MFI=0, PCS_SH_Res=0, Err_*=0. En=1 moves to RUN. The first RUN cycle outputs PCS_MFI=0 with MF_Start=1.
- FSM RUN: PCS_MFI increments by 1 per CE cycle and wraps 255->0. MF_Start is 1 on each cycle where PCS_MFI==0. En=0 moves to STOP.
- FSM STOP: counting continues. On the cycle PCS_MFI==255, the next state is IDLE. If En returns to 1 before that cycle, return to RUN with no count disturbance.
- Reserved channel:
  - 1-deep holding register; Res_Rdy = holding register empty.
  - Res_Vld&Res_Rdy captures Res_Word.
  - On the cycle PCS_MFI==RES_START-1, the holding register transfers to the shift register and Res_Rdy rises next cycle. If the holding register is empty, the shift register loads zeros and Res_Und pulses.
  - No bypass: a word captured in the transfer cycle waits for the next multiframe.
- PCS_SH_Res equals the shift register MSB while PCS_MFI is in RES_START..RES_START+RW-1, shifting once per such cycle; 0 at all other indices.
- Injection acceptance: Inj_Req is accepted only when Inj_Busy=0 and state is RUN. Acceptance latches Inj_Sel and Inj_Num, pulses Inj_Ack, and sets Inj_Busy. An Inj_Req in IDLE, STOP or while busy is ignored (no Ack).
- Injection timing:
  - Selected Err_SH/Err_MF rise on the cycle PCS_MFI next shows 0. They stay high through PCS_MFI==255 of the Nth multiframe and fall with the following 0.
  - Err_CRC covers the same window delayed by 1 CE cycle, matching the inserter's delayed multiframe indication.
  - Inj_Done pulses as the window ends (after the Err_CRC tail if selected); Inj_Busy then falls.
- Injection abort: STOP->IDLE during injection clears Err_* on IDLE entry, pulses Inj_Done, and clears Busy.
- Reset mid-operation returns all state and outputs to reset values immediately.

Decomposition:
- Shared package holds:
  - MF_LEN=256.
  - Reserved-bit span limit 213.
  - Inj_Sel bit positions.
  - FSM state encoding (IDLE, RUN, STOP).
- One sub-module, sici_pcs_res_ser: holding register, shift register, Rdy/Und logic, driven by PCS_MFI.

Test Plan:
- Reset, then En=1 with CE=1 -> PCS_MFI 0,1,..,255,0; MF_Start high exactly when 0; Run=1.
- En dropped at PCS_MFI==100 -> count continues to 255, then PCS_MFI=0 held and Run=0. Repeat with En re-raised at 200 -> no gap in count.
- Res_Word=16'hA5C3 loaded before index 26 -> PCS_SH_Res on indices 27..42 = 1010010111000011, 0 elsewhere. With no word -> zeros and Res_Und pulse at index 26.
- Inj_Sel=3'b011, Inj_Num=2 accepted mid-multiframe -> Err_SH/Err_MF high from next PCS_MFI=0 for 512 CE cycles; Inj_Done pulse; a second Req while busy gets no Ack.
- Inj_Sel=3'b100, Inj_Num=0 -> Err_CRC high for 256 cycles starting one cycle after PCS_MFI=0.
- CE toggled 1/0 randomly -> outputs frozen when CE=0; Rs_n pulsed low mid-injection -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sici_pcs_mf_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the SICI PCS multiframe sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sici_pcs_mf_ctrl_pkg;

  // Multiframe length and the last index before wrap
  localparam int         MF_LEN       = 256;
  localparam logic [7:0] MFI_LAST     = 8'(MF_LEN - 1);

  // Longest reserved-bit span that fits inside one multiframe
  localparam int         RES_SPAN_MAX = 213;

  // Bit positions inside Inj_Sel
  localparam int         INJ_SH       = 0;
  localparam int         INJ_MF       = 1;
  localparam int         INJ_CRC      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } mf_state_e;

  // A request for zero multiframes still corrupts one
  function automatic logic [7:0] inj_num_eff(input logic [7:0] num);
    return (num == 8'd0) ? 8'd1 : num;
  endfunction

endpackage

// File: rtl/sici_pcs_res_ser.sv
// Reserved-channel serializer: 1-deep holding register feeding a shift register that emits PCS_SH_Res.
// Latency: outputs registered and aligned with the PCS_MFI they accompany; word sent in the multiframe after capture.
// Backpressure: Res_Rdy low while the holding register is full; an empty holding register at load point sends zeros and pulses Res_Und.
module sici_pcs_res_ser
  import sici_pcs_mf_ctrl_pkg::*;
#(
  parameter int RW        = 16,
  parameter int RES_START = 27   // must be >= 1 so the load index exists
)
(
  input  logic          Ck,
  input  logic          Rs_n,
  input  logic          CE,
  input  logic [7:0]    i_mfi,      // index currently shown
  input  logic          i_act,      // sequencer currently in RUN/STOP
  input  logic [7:0]    i_mfi_nxt,  // index shown after this edge
  input  logic          i_act_nxt,  // RUN/STOP after this edge
  input  logic [RW-1:0] Res_Word,
  input  logic          Res_Vld,
  output logic          Res_Rdy,
  output logic          Res_Und,
  output logic          o_sh_res
);

  localparam logic [7:0] LP_LOAD  = 8'(RES_START - 1);
  localparam logic [7:0] LP_FIRST = 8'(RES_START);
  localparam logic [7:0] LP_LAST  = 8'(RES_START + RW - 1);

  logic [RW-1:0] r_hold;
  logic [RW-1:0] r_shift;
  logic          r_hold_full;
  logic          r_rdy;
  logic          r_und;
  logic          r_sh_res;

  logic [RW-1:0] w_load;
  logic          w_cap;
  logic          w_xfer;
  logic          w_hold_full_nxt;
  logic          w_in_win;

  // Handshake, transfer point and reserved-bit window decode
  always_comb begin
    w_cap           = Res_Vld && r_rdy;
    w_xfer          = i_act && (i_mfi == LP_LOAD);
    // A word captured on the transfer edge stays in the holding register
    w_hold_full_nxt = w_cap || (r_hold_full && !w_xfer);
    w_load          = r_hold_full ? r_hold : '0;
    w_in_win        = i_act_nxt && (i_mfi_nxt >= LP_FIRST) && (i_mfi_nxt <= LP_LAST);
  end

  // Holding register, ready flag and underflow pulse
  always_ff @(posedge Ck or negedge Rs_n) begin
    if (!Rs_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_rdy       <= 1'b0;
      r_und       <= 1'b0;
    end else if (CE) begin
      if (w_cap) r_hold <= Res_Word;
      r_hold_full <= w_hold_full_nxt;
      r_rdy       <= !w_hold_full_nxt;
      // Shown during the load-index cycle whenever nothing is waiting to be sent
      r_und       <= i_act_nxt && (i_mfi_nxt == LP_LOAD) && !w_hold_full_nxt;
    end
  end

  // Shift register: load on the edge into the first reserved index, shift MSB-first after
  always_ff @(posedge Ck or negedge Rs_n) begin
    if (!Rs_n) begin
      r_shift  <= '0;
      r_sh_res <= 1'b0;
    end else if (CE) begin
      if (w_xfer) begin
        r_sh_res <= w_load[RW-1];
        r_shift  <= w_load << 1;
      end else if (w_in_win) begin
        r_sh_res <= r_shift[RW-1];
        r_shift  <= r_shift << 1;
      end else begin
        r_sh_res <= 1'b0;
      end
    end
  end

  assign Res_Rdy  = r_rdy;
  assign Res_Und  = r_und;
  assign o_sh_res = r_sh_res;

endmodule

// File: rtl/sici_pcs_mf_ctrl.sv
// SICI PCS multiframe sequencer: MFI counter, run/stop FSM, reserved-SH stream and multiframe-aligned error injection.
// Latency: all outputs registered; first RUN cycle shows PCS_MFI=0, Err_CRC trails Err_SH/Err_MF by one CE cycle.
// Backpressure: CE=0 freezes everything; Inj_Req ignored unless RUN and idle; reserved channel via Res_Vld/Res_Rdy.
module sici_pcs_mf_ctrl
  import sici_pcs_mf_ctrl_pkg::*;
#(
  parameter int RW        = 16,
  parameter int RES_START = 27
)
(
  input  logic          Ck,
  input  logic          Rs_n,
  input  logic          CE,
  input  logic          En,
  output logic          Run,
  output logic [7:0]    PCS_MFI,
  output logic          PCS_SH_Res,
  output logic          MF_Start,
  input  logic [RW-1:0] Res_Word,
  input  logic          Res_Vld,
  output logic          Res_Rdy,
  output logic          Res_Und,
  input  logic          Inj_Req,
  input  logic [2:0]    Inj_Sel,
  input  logic [7:0]    Inj_Num,
  output logic          Inj_Ack,
  output logic          Inj_Busy,
  output logic          Inj_Done,
  output logic          Err_SH,
  output logic          Err_MF,
  output logic          Err_CRC
);

  mf_state_e  r_state;
  mf_state_e  w_state_nxt;
  logic [7:0] r_mfi;
  logic [7:0] w_mfi_nxt;
  logic       r_run;
  logic       r_mf_start;
  logic       w_act;
  logic       w_act_nxt;

  logic       r_armed;
  logic       r_win;
  logic       r_busy;
  logic       r_ack;
  logic       r_done;
  logic       r_err_sh;
  logic       r_err_mf;
  logic       r_err_crc;
  logic [2:0] r_sel;
  logic [7:0] r_num;
  logic [7:0] r_cnt;

  logic       w_accept;
  logic       w_mf_edge;
  logic       w_win_start;
  logic       w_win_end;
  logic       w_win_nxt;
  logic       w_abort;
  logic       w_done;

  // FSM state register
  always_ff @(posedge Ck or negedge Rs_n) begin
    if (!Rs_n)   r_state <= ST_IDLE;
    else if (CE) r_state <= w_state_nxt;
  end

  // FSM next state and the index that will be shown after this edge
  always_comb begin
    w_state_nxt = r_state;
    w_mfi_nxt   = r_mfi;
    case (r_state)
      ST_IDLE: begin
        w_mfi_nxt = 8'd0;
        if (En) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_mfi_nxt = r_mfi + 8'd1;
        if (!En) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Finish the current multiframe, then park at index 0
        if (r_mfi == MFI_LAST) begin
          w_state_nxt = ST_IDLE;
          w_mfi_nxt   = 8'd0;
        end else begin
          w_mfi_nxt = r_mfi + 8'd1;
          if (En) w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mfi_nxt   = 8'd0;
      end
    endcase
    w_act     = (r_state != ST_IDLE);
    w_act_nxt = (w_state_nxt != ST_IDLE);
  end

  // Counter, Run and multiframe-start outputs
  always_ff @(posedge Ck or negedge Rs_n) begin
    if (!Rs_n) begin
      r_mfi      <= 8'd0;
      r_run      <= 1'b0;
      r_mf_start <= 1'b0;
    end else if (CE) begin
      r_mfi      <= w_mfi_nxt;
      r_run      <= w_act_nxt;
      r_mf_start <= (w_state_nxt == ST_RUN) && (w_mfi_nxt == 8'd0);
    end
  end

  // Injection window control: start/end on multiframe boundaries, abort on return to IDLE
  always_comb begin
    w_accept    = Inj_Req && !r_busy && (r_state == ST_RUN);
    w_mf_edge   = w_act_nxt && (w_mfi_nxt == 8'd0);
    w_win_start = r_armed && w_mf_edge;
    w_win_end   = r_win && w_mf_edge && (r_cnt == 8'd1);
    w_abort     = r_busy && !w_act_nxt;
    w_win_nxt   = (w_win_start || (r_win && !w_win_end)) && !w_abort;
    // With CRC selected the job is finished only once its delayed tail has dropped
    w_done      = w_abort || (r_sel[INJ_CRC] ? (r_err_crc && !r_win) : w_win_end);
  end

  // Injection registers and error controls
  always_ff @(posedge Ck or negedge Rs_n) begin
    if (!Rs_n) begin
      r_armed   <= 1'b0;
      r_win     <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_done    <= 1'b0;
      r_err_sh  <= 1'b0;
      r_err_mf  <= 1'b0;
      r_err_crc <= 1'b0;
      r_sel     <= 3'd0;
      r_num     <= 8'd0;
      r_cnt     <= 8'd0;
    end else if (CE) begin
      r_ack     <= w_accept;
      r_done    <= w_done;
      r_win     <= w_win_nxt;
      r_err_sh  <= w_win_nxt && r_sel[INJ_SH];
      r_err_mf  <= w_win_nxt && r_sel[INJ_MF];
      r_err_crc <= r_win && r_sel[INJ_CRC] && !w_abort;
      if (w_accept) begin
        r_sel   <= Inj_Sel;
        r_num   <= inj_num_eff(Inj_Num);
        r_armed <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        if (w_win_start || w_abort) r_armed <= 1'b0;
        if (w_done)                 r_busy  <= 1'b0;
      end
      if (w_win_start)             r_cnt <= r_num;
      else if (r_win && w_mf_edge) r_cnt <= r_cnt - 8'd1;
    end
  end

  sici_pcs_res_ser #(
    .RW        (RW),
    .RES_START (RES_START)
  ) u_res_ser (
    .Ck        (Ck),
    .Rs_n      (Rs_n),
    .CE        (CE),
    .i_mfi     (r_mfi),
    .i_act     (w_act),
    .i_mfi_nxt (w_mfi_nxt),
    .i_act_nxt (w_act_nxt),
    .Res_Word  (Res_Word),
    .Res_Vld   (Res_Vld),
    .Res_Rdy   (Res_Rdy),
    .Res_Und   (Res_Und),
    .o_sh_res  (PCS_SH_Res)
  );

  assign Run      = r_run;
  assign PCS_MFI  = r_mfi;
  assign MF_Start = r_mf_start;
  assign Inj_Ack  = r_ack;
  assign Inj_Busy = r_busy;
  assign Inj_Done = r_done;
  assign Err_SH   = r_err_sh;
  assign Err_MF   = r_err_mf;
  assign Err_CRC  = r_err_crc;

endmodule
